// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive and transmit paths.
//   UART_DATA_BITS    : payload bits per frame (8N1)
//   UART_CLKS_PER_BIT : default clk cycles per bit (100 MHz / 9600 baud)
//   uart_rx_state_t   : receiver FSM state encoding
package uart_pkg;
  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 10416;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: 2-flop synchronizer for an asynchronous single-bit input.
//   clk : destination clock
//   rst : asynchronous active-high reset, flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output, 2 cycles of latency
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= {2{RST_VAL}};
    else     sync_pipe <= {sync_pipe[0], d};
  end

  assign q = sync_pipe[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver, LSB first, with a one-entry valid/ready
// holding register.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx        : raw RX pin, asynchronous, idle high
//   data      : received byte, valid when valid=1
//   valid     : holding register full
//   ready     : consumer takes the byte when valid && ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while register full and not drained
//   busy      : receiver is inside a frame (state != IDLE)
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  uart_rx_state_t            state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic [UART_DATA_BITS-1:0] data_n;
  logic                      valid_n, fe_n, ov_n;
  logic                      deliver;
  logic                      rx_s;

  bit_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= fe_n;
      overrun   <= ov_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    deliver   = 1'b0;
    fe_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Re-check the line half a bit in; a high line means a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[UART_DATA_BITS-1:1]};
          if (bit_idx == 3'd7) state_n   = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets IDLE catch a back-to-back start edge.
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        // Wait out a held-low line so it reports only one frame error.
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Holding register: a drain in the same cycle frees the slot for a new byte.
    data_n  = data;
    valid_n = valid;
    ov_n    = 1'b0;
    if (deliver) begin
      if (!valid || ready) begin
        data_n  = shift;
        valid_n = 1'b1;
      end else begin
        ov_n = 1'b1;
      end
    end else if (valid && ready) begin
      valid_n = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule
